// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with private HI/LO.
//   Executes MULTU/MULT (radix-2 shift-add) and DIVU/DIV (restoring
//   division) in ITER cycles, plus one fix-up cycle for sign correction.
//   Uses a start/busy/done handshake.
// Ports:
//   CLK        clock, rising edge
//   reset      synchronous, active-low reset
//   start      request, sampled only in IDLE or DONE
//   op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   srcA       multiplicand / dividend (rs)
//   srcB       multiplier / divisor (rt)
//   busy       high in CALC and FIX
//   done       one-cycle completion pulse (DONE state)
//   divByZero  divide with srcB==0; held until the next accepted start
//   hi, lo     HI/LO registers (product high/low, or remainder/quotient)
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_q, neg_d;     // result (product/quotient) negated
    logic                 rneg_q, rneg_d;   // remainder takes dividend sign
    logic                 zdiv_q, zdiv_d;   // divide-by-zero in flight
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // |multiplicand| or |divisor|
    // Shared work register. Multiply: {partial product hi, multiplier/low}.
    // Divide: {remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0]   w_q, w_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 dbz_q, dbz_d;

    // Operand conditioning at accept time
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a, mag_b;

    assign a_neg = op[0] & srcA[WIDTH-1];
    assign b_neg = op[0] & srcB[WIDTH-1];
    assign mag_a = a_neg ? -srcA : srcA;
    assign mag_b = b_neg ? -srcB : srcB;

    // One multiply step: conditionally add multiplicand to the upper half,
    // then shift the whole 64-bit product right by one.
    logic [WIDTH:0]       madd;
    logic [2*WIDTH-1:0]   mul_next;

    assign madd     = {1'b0, w_q[2*WIDTH-1:WIDTH]} + (w_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {madd, w_q[WIDTH-1:1]};

    // One restoring divide step: 33-bit trial remainder against the divisor.
    // The remainder is always < divisor, so it fits back into 32 bits.
    logic [WIDTH:0]       shifted;
    logic                 ge;
    logic [WIDTH-1:0]     diff;
    logic [2*WIDTH-1:0]   div_next;

    assign shifted  = {w_q[2*WIDTH-1:WIDTH], w_q[WIDTH-1]};
    assign ge       = shifted >= {1'b0, opnd_q};
    assign diff     = shifted[WIDTH-1:0] - opnd_q;
    assign div_next = ge ? {diff, w_q[WIDTH-2:0], 1'b1}
                         : {shifted[WIDTH-1:0], w_q[WIDTH-2:0], 1'b0};

    // Sign fix-up values
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign prod_fix = neg_q  ? -w_q : w_q;
    assign quo_fix  = neg_q  ? -w_q[WIDTH-1:0] : w_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -w_q[2*WIDTH-1:WIDTH] : w_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        zdiv_d  = zdiv_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        w_d     = w_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d   = op;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    cnt_d  = '0;
                    dbz_d  = 1'b0;
                    zdiv_d = 1'b0;
                    state_d = S_CALC;
                    if (op[1]) begin
                        opnd_d = mag_b;
                        w_d    = {{WIDTH{1'b0}}, mag_a};
                        if (srcB == '0) begin
                            // Keep the raw dividend; it becomes HI.
                            zdiv_d  = 1'b1;
                            w_d     = {{WIDTH{1'b0}}, srcA};
                            state_d = S_FIX;
                        end
                    end else begin
                        opnd_d = mag_a;
                        w_d    = {{WIDTH{1'b0}}, mag_b};
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                w_d   = op_q[1] ? div_next : mul_next;
                if (cnt_q == CW'(ITER - 1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                if (zdiv_q) begin
                    lo_d  = '1;
                    hi_d  = w_q[WIDTH-1:0];
                    dbz_d = 1'b1;
                end else if (op_q[1]) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    lo_d = prod_fix[WIDTH-1:0];
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            zdiv_q  <= 1'b0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            w_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            zdiv_q  <= zdiv_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            w_q     <= w_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign divByZero = dbz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        busy, done, divByZero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .CLK(CLK), .reset(reset), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .busy(busy), .done(done),
        .divByZero(divByZero), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    // Drive a request so it is sampled at the next edge (E0); return #1 after E0.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    // Step edge by edge until done; lat = edges after E0, bcyc = busy cycles seen.
    task automatic wait_done(output int lat, output int bcyc, output bit to);
        lat = 0; bcyc = 0; to = 1'b0;
        while (!done) begin
            if (busy) bcyc++;
            @(posedge CLK); #1;
            lat++;
            if (lat > 200) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({busy, done, divByZero} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, divByZero});
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi, lo);
        end
        reset = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_multu();
        int lat, bc; bit to;
        launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bc, to);
        checks++;
        if (to || lat != 33) begin
            errors++; $display("FAIL multu_latency: got %0d (timeout=%0d) expected 33", lat, to);
        end
        checks++;
        if (bc != 33) begin
            errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc);
        end
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", hi, lo);
        end
        @(posedge CLK); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL multu_done_pulse: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit to;
        launch(2'b01, 32'hFFFFFFFD, 32'd7);
        wait_done(lat, bc, to);
        checks++;
        if (to || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            errors++; $display("FAIL mult_signed: got %h_%h expected ffffffff_ffffffeb", hi, lo);
        end
        // Start sampled in the DONE cycle
        launch(2'b11, 32'hFFFFFFF9, 32'd2);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy);
        end
        wait_done(lat, bc, to);
        checks++;
        if (to || lat != 33) begin
            errors++; $display("FAIL b2b_latency: got %0d expected 33", lat);
        end
        checks++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL div_signed: got hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_div_by_zero();
        int lat, bc; bit to;
        launch(2'b10, 32'd100, 32'd0);
        wait_done(lat, bc, to);
        checks++;
        if (to || lat != 1) begin
            errors++; $display("FAIL dbz_latency: got %0d expected 1", lat);
        end
        checks++;
        if (divByZero !== 1'b1 || lo !== 32'hFFFFFFFF || hi !== 32'h00000064) begin
            errors++; $display("FAIL dbz_result: got dbz=%b hi=%h lo=%h expected 1/00000064/ffffffff",
                               divByZero, hi, lo);
        end
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (divByZero !== 1'b1) begin
            errors++; $display("FAIL dbz_hold: got %b expected 1", divByZero);
        end
        // Signed overflow case; the accepted start must clear divByZero.
        launch(2'b11, 32'h80000000, 32'hFFFFFFFF);
        checks++;
        if (divByZero !== 1'b0) begin
            errors++; $display("FAIL dbz_clear: got %b expected 0", divByZero);
        end
        wait_done(lat, bc, to);
        checks++;
        if (to || lo !== 32'h80000000 || hi !== 32'h0 || divByZero !== 1'b0) begin
            errors++; $display("FAIL div_overflow: got hi=%h lo=%h dbz=%b expected 0/80000000/0",
                               hi, lo, divByZero);
        end
        @(posedge CLK); #1;
        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, bc, to);
        checks++;
        if (to || lo !== 32'h0 || hi !== 32'h80000000) begin
            errors++; $display("FAIL divu_big: got hi=%h lo=%h expected 80000000/0", hi, lo);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_ignore_start();
        int lat, bc, pulses; bit to;
        launch(2'b00, 32'd5, 32'd6);
        repeat (3) begin @(posedge CLK); #1; end
        op = 2'b10; srcA = 32'd1234; srcB = 32'd7; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; srcA = 32'd99; srcB = 32'd0;
        wait_done(lat, bc, to);
        checks++;
        if (to || lat + 4 != 33) begin
            errors++; $display("FAIL ignore_latency: got %0d expected 33", lat + 4);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'd30) begin
            errors++; $display("FAIL ignore_result: got hi=%h lo=%h expected 0/0000001e", hi, lo);
        end
        pulses = done ? 1 : 0;
        repeat (6) begin
            @(posedge CLK); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc; bit to;
        launch(2'b10, 32'd1000, 32'd3);
        repeat (9) begin @(posedge CLK); #1; end
        reset = 1'b0;
        @(posedge CLK); #1;
        reset = 1'b1;
        checks++;
        if ({busy, done, divByZero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL abort_state: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all 0",
                               busy, done, divByZero, hi, lo);
        end
        @(posedge CLK); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got busy=%b done=%b expected 0/0", busy, done);
        end
        launch(2'b10, 32'd1000, 32'd3);
        wait_done(lat, bc, to);
        checks++;
        if (to || lat != 33 || lo !== 32'd333 || hi !== 32'd1) begin
            errors++; $display("FAIL divu_after_abort: got lat=%0d hi=%0d lo=%0d expected 33/1/333", lat, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_back_to_back();
        test_div_by_zero();
        test_ignore_start();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
